// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master engine.
package spi_pkg;
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LATCH,
        SHIFT_LO,
        SHIFT_HI,
        PUSH,
        DONE
    } spi_state_t;

    localparam int   SPI_LEN_W    = 16;
    localparam logic SPI_OP_READ  = 1'b0;
    localparam logic SPI_OP_WRITE = 1'b1;
endpackage

// File: rtl/spi_master_core_if.sv
// Sequencer, FIFO and SPI pin bundle seen by the SPI master engine.
interface spi_master_core_if import spi_pkg::*; #(parameter int DATA = 8);
    logic [SPI_LEN_W-1:0] len;
    logic                 op;
    logic                 work;
    logic                 busy;
    logic [DATA-1:0]      tx_rdata;
    logic                 tx_rd;
    logic                 tx_empty;
    logic [DATA-1:0]      rx_wdata;
    logic                 rx_wr;
    logic                 rx_full;
    logic                 sclk;
    logic                 cs_n;
    logic                 mosi;
    logic                 miso;

    modport master (
        input  len, op, work, tx_rdata, tx_empty, rx_full, miso,
        output busy, tx_rd, rx_wdata, rx_wr, sclk, cs_n, mosi
    );

    modport slave (
        output len, op, work, tx_rdata, tx_empty, rx_full, miso,
        input  busy, tx_rd, rx_wdata, rx_wr, sclk, cs_n, mosi
    );
endinterface

// File: rtl/spi_sclk_div.sv
// Phase timer: start loads CLK_DIV-1, tick is high on the last cycle of the phase.
module spi_sclk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic tick
);
    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (start)
            cnt <= TERM;
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign tick = (cnt == '0);
endmodule

// File: rtl/spi_master_core.sv
// SPI mode-0 master: pops TX bytes, shifts them out MSB first, pushes captured
// MISO bytes to the RX FIFO, with chip-select framing around the whole frame.
module spi_master_core import spi_pkg::*; #(
    parameter int DATA    = 8,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_core_if.master  bus
);
    localparam int                   BW       = $clog2(DATA + 1);
    localparam logic [SPI_LEN_W-1:0] DATA_LEN = SPI_LEN_W'(DATA);

    spi_state_t           state, state_nxt;
    logic [SPI_LEN_W-1:0] rem;
    logic [BW-1:0]        byte_bits;
    logic                 op_q;
    logic                 popped;
    logic [DATA-1:0]      tx_sr;
    logic [DATA-1:0]      rx_sr;
    logic                 div_start;
    logic                 div_tick;

    spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .tick  (div_tick)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.work && bus.len != '0) state_nxt = LOAD;
            LOAD:     state_nxt = LATCH;
            LATCH:    state_nxt = SHIFT_LO;
            SHIFT_LO: if (div_tick) state_nxt = SHIFT_HI;
            SHIFT_HI: if (div_tick) state_nxt = (byte_bits == BW'(1)) ? PUSH : SHIFT_LO;
            PUSH:     if (op_q == SPI_OP_WRITE || !bus.rx_full)
                          state_nxt = (rem != '0) ? LOAD : DONE;
            DONE:     if (div_tick) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        // Every timed phase restarts the divider on entry.
        div_start = (state_nxt != state) &&
                    (state_nxt == SHIFT_LO || state_nxt == SHIFT_HI || state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem       <= '0;
            byte_bits <= '0;
            op_q      <= SPI_OP_READ;
            popped    <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.work && bus.len != '0) begin
                    rem  <= bus.len;
                    op_q <= bus.op;
                end
                LOAD: popped <= !bus.tx_empty;
                LATCH: begin
                    tx_sr     <= popped ? bus.tx_rdata : '0;
                    rx_sr     <= '0;
                    byte_bits <= (rem >= DATA_LEN) ? BW'(DATA) : BW'(rem);
                end
                // MISO is captured on the edge that raises SCK.
                SHIFT_LO: if (div_tick) rx_sr <= {rx_sr[DATA-2:0], bus.miso};
                SHIFT_HI: if (div_tick) begin
                    tx_sr     <= {tx_sr[DATA-2:0], 1'b0};
                    byte_bits <= byte_bits - BW'(1);
                    if (rem != '0)
                        rem <= rem - SPI_LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.cs_n     = (state == IDLE) || (state == DONE);
    assign bus.sclk     = (state == SHIFT_HI);
    assign bus.mosi     = (state == SHIFT_LO || state == SHIFT_HI) && tx_sr[DATA-1];
    assign bus.tx_rd    = (state == LOAD) && !bus.tx_empty;
    assign bus.rx_wr    = (state == PUSH) && (op_q == SPI_OP_READ) && !bus.rx_full;
    assign bus.rx_wdata = rx_sr;
endmodule

// File: tb/tb_spi_master_core.sv
// Directed scoreboard bench for spi_master_core: a FIFO/slave model drives the
// DUT and a negedge monitor checks MOSI bytes and RX pushes against queues.
`timescale 1ns/1ps
module tb_spi_master_core;
    import spi_pkg::*;

    localparam int DATA    = 8;
    localparam int CLK_DIV = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_core_if #(.DATA(DATA)) bus();

    spi_master_core #(.DATA(DATA), .CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, exp);
        end
    endtask

    // TX FIFO model: data appears the cycle after the pop strobe
    logic [7:0] txmem [64];
    int wptr = 0;
    int rptr = 0;
    int pops = 0;
    assign bus.tx_empty = (rptr == wptr);
    always @(posedge clk) begin
        if (bus.tx_rd) begin
            bus.tx_rdata <= txmem[rptr % 64];
            rptr         <= rptr + 1;
            pops         <= pops + 1;
        end
    end

    task automatic push_tx(input logic [7:0] b);
        txmem[wptr % 64] = b;
        wptr++;
    endtask

    // Slave model: returns miso_byte MSB first on every byte of the frame
    logic [7:0] miso_byte = 8'h00;
    int rises      = 0;
    int rises_low  = 0;
    int frame_base = 0;
    int pushes     = 0;
    always_comb bus.miso = miso_byte[3'(7 - ((rises - frame_base) % 8))];

    logic [7:0] exp_rx[$];
    logic [7:0] exp_mosi[$];

    logic       prev_sclk = 1'b0;
    int         mosi_n    = 0;
    logic [7:0] mosi_acc  = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            mosi_n    = 0;
            prev_sclk = 1'b0;
        end else begin
            if (bus.sclk && !prev_sclk) begin
                rises++;
                if (!bus.cs_n) rises_low++;
                mosi_acc = {mosi_acc[6:0], bus.mosi};
                mosi_n++;
                if (mosi_n == 8) begin
                    mosi_n = 0;
                    if (exp_mosi.size() == 0) begin
                        total++; bad++;
                        $display("FAIL mosi_extra: got=0x%0h want=none", mosi_acc);
                    end else
                        chk("mosi_byte", mosi_acc, exp_mosi.pop_front());
                end
            end
            if (bus.cs_n) mosi_n = 0;
            if (bus.rx_wr) begin
                pushes++;
                if (exp_rx.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rx_extra: got=0x%0h want=none", bus.rx_wdata);
                end else
                    chk("rx_byte", bus.rx_wdata, exp_rx.pop_front());
            end
            if (bus.tx_rd || bus.rx_wr) begin
                chk("strobe_excl", int'(bus.tx_rd & bus.rx_wr), 0);
                chk("strobe_busy", int'(bus.busy), 1);
            end
            prev_sclk = bus.sclk;
        end
    end

    task automatic run_frame(input string name, input logic [15:0] l, input logic o,
                             input int exp_cyc, input int glitch_at);
        int cyc;
        frame_base = rises;
        @(negedge clk);
        bus.len  = l;
        bus.op   = o;
        bus.work = 1'b1;
        @(negedge clk);
        bus.work = 1'b0;
        chk({name, "_busy_rise"}, int'(bus.busy), 1);
        chk({name, "_cs_fall"}, int'(bus.cs_n), 0);
        cyc = 0;
        while (bus.busy && cyc < 3000) begin
            cyc++;
            bus.work = (cyc == glitch_at);
            if (cyc == glitch_at) bus.len = 16'd16;
            @(negedge clk);
        end
        bus.work = 1'b0;
        chk({name, "_busy_cycles"}, cyc, exp_cyc);
        chk({name, "_rx_left"}, exp_rx.size(), 0);
        chk({name, "_mosi_left"}, exp_mosi.size(), 0);
    endtask

    task automatic stall_first_push();
        int   n     = 0;
        int   guard = 0;
        logic pv    = 1'b0;
        bus.rx_full = 1'b1;
        while (!(n == 8 && !bus.sclk) && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (bus.sclk && !pv) n++;
            pv = bus.sclk;
        end
        chk("bp_push_reached", int'(guard < 1000), 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_sclk_low", int'(bus.sclk), 0);
            chk("bp_cs_low", int'(bus.cs_n), 0);
            chk("bp_no_wr", int'(bus.rx_wr), 0);
            @(negedge clk);
        end
        bus.rx_full = 1'b0;
    endtask

    initial begin
        int p0, q0, r0, rl0, n, guard;
        logic pv;
        bus.len     = '0;
        bus.op      = SPI_OP_READ;
        bus.work    = 1'b0;
        bus.rx_full = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_cs_n", int'(bus.cs_n), 1);
        chk("rst_sclk", int'(bus.sclk), 0);
        chk("rst_mosi", int'(bus.mosi), 0);
        chk("rst_tx_rd", int'(bus.tx_rd), 0);
        chk("rst_rx_wr", int'(bus.rx_wr), 0);
        chk("rst_rx_wdata", int'(bus.rx_wdata), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full read: 3 real bytes then two dummies, slave answers 0xA5
        push_tx(8'hF0); push_tx(8'h19); push_tx(8'h00);
        miso_byte = 8'hA5;
        repeat (5) exp_rx.push_back(8'hA5);
        exp_mosi.push_back(8'hF0); exp_mosi.push_back(8'h19);
        exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h00);
        p0 = pops; q0 = pushes; r0 = rises; rl0 = rises_low;
        run_frame("read", 16'd40, SPI_OP_READ, 258, 0);
        chk("read_pops", pops - p0, 3);
        chk("read_pushes", pushes - q0, 5);
        chk("read_rises", rises - r0, 40);
        chk("read_rises_cs_low", rises_low - rl0, 40);

        // Write-only
        push_tx(8'h3C); push_tx(8'hC3);
        miso_byte = 8'hFF;
        exp_mosi.push_back(8'h3C); exp_mosi.push_back(8'hC3);
        p0 = pops; q0 = pushes;
        run_frame("write", 16'd16, SPI_OP_WRITE, 105, 0);
        chk("write_pops", pops - p0, 2);
        chk("write_pushes", pushes - q0, 0);

        // Partial final byte
        push_tx(8'hA7);
        miso_byte = 8'hFF;
        exp_rx.push_back(8'hFF); exp_rx.push_back(8'h0F);
        exp_mosi.push_back(8'hA7);
        p0 = pops; q0 = pushes; r0 = rises;
        run_frame("partial", 16'd12, SPI_OP_READ, 81, 0);
        chk("partial_pops", pops - p0, 1);
        chk("partial_pushes", pushes - q0, 2);
        chk("partial_rises", rises - r0, 12);

        // RX backpressure on the first push
        push_tx(8'h55); push_tx(8'hAA);
        miso_byte = 8'h3C;
        exp_rx.push_back(8'h3C); exp_rx.push_back(8'h3C);
        exp_mosi.push_back(8'h55); exp_mosi.push_back(8'hAA);
        q0 = pushes;
        fork
            run_frame("bp", 16'd16, SPI_OP_READ, 115, 0);
            stall_first_push();
        join
        chk("bp_pushes", pushes - q0, 2);

        // Zero-length request is ignored
        p0 = pops;
        @(negedge clk);
        bus.len  = 16'd0;
        bus.work = 1'b1;
        @(negedge clk);
        bus.work = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("len0_busy", int'(bus.busy), 0);
            chk("len0_cs_n", int'(bus.cs_n), 1);
            @(negedge clk);
        end
        chk("len0_pops", pops - p0, 0);

        // work pulse during a frame has no effect
        push_tx(8'h5A);
        miso_byte = 8'h96;
        exp_rx.push_back(8'h96);
        exp_mosi.push_back(8'h5A);
        p0 = pops; q0 = pushes;
        run_frame("glitch", 16'd8, SPI_OP_READ, 54, 10);
        for (int i = 0; i < 5; i++) begin
            chk("glitch_idle", int'(bus.busy), 0);
            @(negedge clk);
        end
        chk("glitch_pops", pops - p0, 1);
        chk("glitch_pushes", pushes - q0, 1);

        // Reset during the first high phase of byte 2
        push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
        miso_byte = 8'h81;
        exp_rx.push_back(8'h81);
        exp_mosi.push_back(8'h11);
        p0 = pops; q0 = pushes;
        frame_base = rises;
        @(negedge clk);
        bus.len  = 16'd24;
        bus.op   = SPI_OP_READ;
        bus.work = 1'b1;
        @(negedge clk);
        bus.work = 1'b0;
        n = 0; guard = 0; pv = 1'b0;
        while (!(n == 9 && bus.sclk) && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (bus.sclk && !pv) n++;
            pv = bus.sclk;
        end
        chk("mid_rst_reached", int'(guard < 1000), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs_n", int'(bus.cs_n), 1);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_sclk", int'(bus.sclk), 0);
        chk("mid_rst_mosi", int'(bus.mosi), 0);
        chk("mid_rst_rx_wdata", int'(bus.rx_wdata), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_rst_pops", pops - p0, 2);
        chk("mid_rst_pushes", pushes - q0, 1);
        chk("mid_rst_busy_after", int'(bus.busy), 0);
        chk("mid_rst_rx_left", exp_rx.size(), 0);
        chk("mid_rst_mosi_left", exp_mosi.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
